main_memory_controller: RTL and testbench
=========================================

// Module: main_memory_controller
// PURPOSE
//   Backing-store side of the cache: sits directly downstream of memoriaCache and services its misses.
//   On a miss it first writes back the dirty victim (when the cache flags writeBack), then reads the requested word.
//   It returns the word to the cache as a one-cycle fill pulse.
//   Holds the 32 x 3-bit main memory behind a fixed, parameterised access latency.
// PARAMETERS
//   ADDR_W   5  word address width; {tag[2:0], index}; memory depth = 2**ADDR_W
//   DATA_W   3  data word width; matches cache data/dadoParaCPU width
//   LATENCY  3  cycles per memory access (write or read); legal range 1..15
// PORTS
//   clock       in   1       single clock; all state updates on rising edge
//   reset       in   1       synchronous, active-high reset
//   miss_req    in   1       cache miss request; level, held by cache until fill_valid
//   miss_addr   in   ADDR_W  address of the missing word
//   wb_en       in   1       cache writeBack flag: victim line is dirty, write it first
//   wb_addr     in   ADDR_W  victim address {victim tag, index}
//   wb_data     in   DATA_W  victim data
//   fill_valid  out  1       one-cycle pulse: fill_data/fill_addr valid for the cache
//   fill_addr   out  ADDR_W  address being filled (equals captured miss_addr)
//   fill_data   out  DATA_W  word read from main memory
//   busy        out  1       high from the cycle after acceptance through the fill_valid cycle
// BEHAVIOUR
//   Reset (sync, any state):
//   - state=IDLE; fill_valid=0, busy=0, fill_addr=0, fill_data=0, counter=0
//   - mem[i] <= i[DATA_W-1:0] for all i
//   - any pending write-back or read is discarded
//   FSM states: IDLE, WB, RD, RESP.
//   - IDLE: busy=0. If miss_req=1 at an edge:
//     - capture miss_addr, wb_en, wb_addr, wb_data into holding registers
//     - go to WB if wb_en=1, else go to RD; load counter=LATENCY-1
//     - inputs are not sampled again until the FSM returns to IDLE
//   - WB: count down; at the edge where counter==0, write mem[wb_addr_q] <= wb_data_q, then go to RD with counter=LATENCY-1.
//   - RD: count down; at the edge where counter==0:
//     - fill_data <= mem[miss_addr_q] (value after any write-back in this transaction)
//     - fill_addr <= miss_addr_q
//     - go to RESP
//   - RESP: fill_valid=1 for exactly this one cycle, busy=1; next edge goes to IDLE unconditionally.
//   Latency, acceptance edge E0 with LATENCY=L:
//   - wb_en=0: fill_valid high in the cycle after edge E_L
//   - wb_en=1: fill_valid high in the cycle after edge E_2L
//   Handshake:
//   - the cache drops miss_req in the fill_valid cycle
//   - if miss_req is still high when IDLE is re-entered, a new transaction is accepted (no implicit dedupe)
//   Ordering and boundaries:
//   - wb_addr == miss_addr: the read returns wb_data; write precedes read
//   - LATENCY=1: each access takes exactly one cycle in WB/RD, with the counter loaded to 0
//   - address 31: legal, no wrap; addresses are always in range by width
//   - miss_req and reset high together: reset wins, request is dropped
//   fill_data and fill_addr hold their last values outside RESP; only fill_valid qualifies them.
// STRUCTURE
//   Shared package mem_pkg:
//   - ADDR_W, DATA_W, LATENCY defaults
//   - typedef mem_state_t {IDLE, WB, RD, RESP}
//   - typedef addr_t, data_t
//   Counter width: $clog2(LATENCY)+1.
//   Sub-module main_mem_array:
//   - 2**ADDR_W x DATA_W storage
//   - synchronous write with wr_en/wr_addr/wr_data
//   - combinational read on rd_addr
//   - synchronous reset init mem[i]=i
//   The controller holds only the FSM, counter and holding registers.
// TESTING
//   1. Reset, miss_req=1, miss_addr=5'b10000, wb_en=0, L=3 -> fill_valid 1 cycle after edge 3; fill_data=0, fill_addr=16; busy 0 after.
//   2. miss_req, miss_addr=5'b00011, wb_en=1, wb_addr=5'b10011, wb_data=3'd6 -> fill after edge 6; fill_data=3; then a miss on 5'b10011 returns 6.
//   3. wb_en=1, wb_addr=miss_addr=5'b01010, wb_data=3'd7 -> fill_data=7 (write-before-read).
//   4. miss_req held high through fill_valid -> second identical transaction starts on IDLE re-entry; new miss_addr while busy is ignored.
//   5. reset asserted during WB (edge 2) -> next cycle busy=0, fill_valid never pulses; mem[wb_addr] still equals wb_addr[2:0].
//   6. LATENCY=1 build: wb_en=0 fill one cycle after edge 1; wb_en=1 fill one cycle after edge 2.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and defaults for the main-memory side of the cache.
// Word address is {tag[2:0], index}; depth follows from ADDR_W.
package mem_pkg;

    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 3;
    localparam int LATENCY = 3;
    localparam int DEPTH   = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        RD,
        RESP
    } mem_state_t;

endpackage

// File: rtl/main_memory_controller_if.sv
// Miss/fill bundle between the cache (master) and the
// main memory controller (slave).
interface main_memory_controller_if;
    import mem_pkg::*;

    logic  miss_req;
    addr_t miss_addr;
    logic  wb_en;
    addr_t wb_addr;
    data_t wb_data;
    logic  fill_valid;
    addr_t fill_addr;
    data_t fill_data;
    logic  busy;

    modport master (
        output miss_req,
        output miss_addr,
        output wb_en,
        output wb_addr,
        output wb_data,
        input  fill_valid,
        input  fill_addr,
        input  fill_data,
        input  busy
    );

    modport slave (
        input  miss_req,
        input  miss_addr,
        input  wb_en,
        input  wb_addr,
        input  wb_data,
        output fill_valid,
        output fill_addr,
        output fill_data,
        output busy
    );

endinterface

// File: rtl/main_mem_array.sv
// Backing store: synchronous write, combinational read,
// reset loads every word with the low bits of its own address.
module main_mem_array
    import mem_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  wr_en,
    input  addr_t wr_addr,
    input  data_t wr_data,
    input  addr_t rd_addr,
    output data_t rd_data
);

    data_t mem [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= data_t'(i);
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/main_memory_controller.sv
// Services cache misses: optional dirty write-back, then a read,
// each taking LATENCY cycles, returned as a one-cycle fill pulse.
module main_memory_controller #(
    parameter int LATENCY = mem_pkg::LATENCY
) (
    input  logic                     clock,
    input  logic                     reset,
    main_memory_controller_if.slave  bus
);
    import mem_pkg::*;

    localparam int CW = $clog2(LATENCY) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    mem_state_t    state_q;
    mem_state_t    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    addr_t miss_addr_q;
    addr_t wb_addr_q;
    data_t wb_data_q;
    addr_t fill_addr_q;
    data_t fill_data_q;

    logic  accept;
    logic  wr_en;
    logic  rd_done;
    data_t rd_data;

    main_mem_array u_array (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wb_addr_q),
        .wr_data (wb_data_q),
        .rd_addr (miss_addr_q),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        wr_en   = 1'b0;
        rd_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.miss_req) begin
                    accept  = 1'b1;
                    state_d = bus.wb_en ? WB : RD;
                    cnt_d   = CNT_LOAD;
                end
            end
            WB: begin
                if (cnt_q == '0) begin
                    wr_en   = 1'b1;
                    state_d = RD;
                    cnt_d   = CNT_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RD: begin
                if (cnt_q == '0) begin
                    rd_done = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            miss_addr_q <= '0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            fill_addr_q <= '0;
            fill_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                miss_addr_q <= bus.miss_addr;
                wb_addr_q   <= bus.wb_addr;
                wb_data_q   <= bus.wb_data;
            end
            // Write-back has already landed, so the read sees it.
            if (rd_done) begin
                fill_addr_q <= miss_addr_q;
                fill_data_q <= rd_data;
            end
        end
    end

    assign bus.fill_valid = (state_q == RESP);
    assign bus.busy       = (state_q != IDLE);
    assign bus.fill_addr  = fill_addr_q;
    assign bus.fill_data  = fill_data_q;

endmodule

// File: tb/tb_main_memory_controller.sv
// Bench for main_memory_controller: directed table, handshake and
// reset corner cases, random traffic against a word-array model.
module tb_main_memory_controller;
    import mem_pkg::*;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    main_memory_controller_if bus3 ();
    main_memory_controller_if bus1 ();

    main_memory_controller #(.LATENCY(3)) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (bus3.slave)
    );

    main_memory_controller #(.LATENCY(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1.slave)
    );

    typedef struct {
        addr_t ma;
        logic  we;
        addr_t wa;
        data_t wd;
        data_t exp;
    } vec_t;

    vec_t  vecs [5];
    data_t model [DEPTH];
    int    checks = 0;
    int    fails  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model[i] = data_t'(i);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus3.miss_req = 1'b0;
        bus1.miss_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    // One full transaction on the LATENCY=3 instance.
    task automatic run3(input string tag, input addr_t ma, input logic we,
                        input addr_t wa, input data_t wd,
                        input bit has_exp, input data_t exp_d);
        int    n;
        data_t md;
        bus3.miss_req  = 1'b1;
        bus3.miss_addr = ma;
        bus3.wb_en     = we;
        bus3.wb_addr   = wa;
        bus3.wb_data   = wd;
        tick();
        check({tag, " busy"}, bus3.busy, 1);
        n = 0;
        while (!bus3.fill_valid && n < 40) begin
            tick();
            n++;
        end
        bus3.miss_req = 1'b0;
        if (we) model[wa] = wd;
        md = model[ma];
        check({tag, " latency"}, n, we ? 6 : 3);
        check({tag, " data"}, bus3.fill_data, md);
        if (has_exp) check({tag, " data_tbl"}, bus3.fill_data, exp_d);
        check({tag, " addr"}, bus3.fill_addr, ma);
        tick();
        check({tag, " pulse"}, bus3.fill_valid, 0);
        check({tag, " idle"}, bus3.busy, 0);
    endtask

    // LATENCY=1 instance, expectations given directly.
    task automatic run1(input string tag, input addr_t ma, input logic we,
                        input addr_t wa, input data_t wd,
                        input int exp_n, input data_t exp_d);
        int n;
        bus1.miss_req  = 1'b1;
        bus1.miss_addr = ma;
        bus1.wb_en     = we;
        bus1.wb_addr   = wa;
        bus1.wb_data   = wd;
        tick();
        n = 0;
        while (!bus1.fill_valid && n < 40) begin
            tick();
            n++;
        end
        bus1.miss_req = 1'b0;
        check({tag, " latency"}, n, exp_n);
        check({tag, " data"}, bus1.fill_data, exp_d);
        check({tag, " addr"}, bus1.fill_addr, ma);
        tick();
        check({tag, " idle"}, bus1.busy, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int    n;
        int    pulses;
        addr_t ma;
        addr_t wa;
        logic  we;
        data_t wd;

        vecs[0] = '{5'd16, 1'b0, 5'd0,  3'd0, 3'd0};
        vecs[1] = '{5'd3,  1'b1, 5'd19, 3'd6, 3'd3};
        vecs[2] = '{5'd19, 1'b0, 5'd0,  3'd0, 3'd6};
        vecs[3] = '{5'd10, 1'b1, 5'd10, 3'd7, 3'd7};
        vecs[4] = '{5'd31, 1'b0, 5'd0,  3'd0, 3'd7};

        reset = 1'b1;
        bus3.miss_req = 1'b0; bus3.miss_addr = '0; bus3.wb_en = 1'b0;
        bus3.wb_addr = '0; bus3.wb_data = '0;
        bus1.miss_req = 1'b0; bus1.miss_addr = '0; bus1.wb_en = 1'b0;
        bus1.wb_addr = '0; bus1.wb_data = '0;
        do_reset();

        check("rst fill_valid", bus3.fill_valid, 0);
        check("rst busy", bus3.busy, 0);
        check("rst fill_addr", bus3.fill_addr, 0);
        check("rst fill_data", bus3.fill_data, 0);

        for (int i = 0; i < 5; i++) begin
            run3($sformatf("vec%0d", i), vecs[i].ma, vecs[i].we,
                 vecs[i].wa, vecs[i].wd, 1'b1, vecs[i].exp);
        end

        // miss_req held through fill: back-to-back transaction
        bus3.miss_req  = 1'b1;
        bus3.miss_addr = 5'd5;
        bus3.wb_en     = 1'b0;
        tick();
        bus3.miss_addr = 5'd9;
        n = 0;
        while (!bus3.fill_valid && n < 40) begin
            tick();
            n++;
        end
        check("hold lat1", n, 3);
        check("hold addr1", bus3.fill_addr, 5);
        check("hold data1", bus3.fill_data, model[5]);
        bus3.miss_addr = 5'd5;
        tick();
        check("hold idle gap", bus3.busy, 0);
        tick();
        check("hold reaccept", bus3.busy, 1);
        n = 0;
        while (!bus3.fill_valid && n < 40) begin
            tick();
            n++;
        end
        bus3.miss_req = 1'b0;
        check("hold lat2", n, 3);
        check("hold addr2", bus3.fill_addr, 5);
        tick();
        check("hold done", bus3.busy, 0);

        // reset during write-back discards it
        do_reset();
        bus3.miss_req  = 1'b1;
        bus3.miss_addr = 5'd1;
        bus3.wb_en     = 1'b1;
        bus3.wb_addr   = 5'd20;
        bus3.wb_data   = 3'd5;
        tick();
        tick();
        reset = 1'b1;
        bus3.miss_req = 1'b0;
        tick();
        check("wbrst busy", bus3.busy, 0);
        check("wbrst pulse", bus3.fill_valid, 0);
        reset = 1'b0;
        model_reset();
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus3.fill_valid) pulses++;
        end
        check("wbrst no fill", pulses, 0);
        run3("wbrst mem", 5'd20, 1'b0, 5'd0, 3'd0, 1'b1, 3'd4);

        // reset and miss_req together: request dropped
        reset = 1'b1;
        bus3.miss_req  = 1'b1;
        bus3.miss_addr = 5'd7;
        bus3.wb_en     = 1'b0;
        tick();
        reset = 1'b0;
        bus3.miss_req = 1'b0;
        model_reset();
        tick();
        check("rst+req busy", bus3.busy, 0);

        for (int i = 0; i < 40; i++) begin
            ma = addr_t'($urandom_range(0, DEPTH - 1));
            we = 1'($urandom_range(0, 1));
            wa = ($urandom_range(0, 3) == 0) ? ma
                 : addr_t'($urandom_range(0, DEPTH - 1));
            wd = data_t'($urandom_range(0, 7));
            run3($sformatf("rnd%0d", i), ma, we, wa, wd, 1'b0, 3'd0);
        end

        do_reset();
        run1("l1 rd", 5'd7, 1'b0, 5'd0, 3'd0, 1, 3'd7);
        run1("l1 wb", 5'd2, 1'b1, 5'd2, 3'd1, 2, 3'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
